// File: rtl/discus_loader.sv
// discus_loader: loads a checksummed byte frame into discus program memory over the snoop port.
//   clk       : single clock, shared with the discus core and its snoop port
//   reset     : asynchronous, active-low
//   in_data   : stream byte, accepted when in_valid & in_ready
//   in_ready  : registered, rises one edge after reset release and stays high
//   snoopa/d  : write address / data, held between strobes
//   snoopp    : one-cycle write strobe per payload byte
//   snoopm    : memory space select, tied to SPACE
//   cpu_reset : holds the core in reset until a frame passes its checksum
//   busy      : frame in progress
//   error     : last frame failed (bad checksum or timeout)
module discus_loader #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1000,
    parameter logic       SPACE   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] snoopa,
    output logic [7:0] snoopd,
    output logic       snoopp,
    output logic       snoopm,
    output logic       cpu_reset,
    output logic       busy,
    output logic       error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM, RUN} state_t;
    state_t        state_q, state_d;
    logic [7:0]    ptr_q, ptr_d;
    logic [7:0]    sum_q, sum_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    snoopa_q, snoopa_d;
    logic [7:0]    snoopd_q, snoopd_d;
    logic          snoopp_q, snoopp_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic          in_ready_q, in_ready_d;
    logic          xfer;
    logic [7:0]    sum_nx;
    assign xfer   = in_valid & in_ready_q;
    assign sum_nx = sum_q + in_data;
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        snoopa_d    = snoopa_q;
        snoopd_d    = snoopd_q;
        snoopp_d    = 1'b0;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        error_d     = error_q;
        in_ready_d  = 1'b1;
        case (state_q)
            IDLE, RUN: begin
                if (xfer && in_data == SYNC) begin
                    state_d     = ADDR;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    error_d     = 1'b0;
                    sum_d       = 8'h00;
                end
            end
            ADDR: begin
                if (xfer) begin
                    ptr_d   = in_data;
                    sum_d   = sum_nx;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (xfer) begin
                    // a zero count byte encodes a full 256-byte payload
                    cnt_d   = {(in_data == 8'h00), in_data};
                    sum_d   = sum_nx;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    snoopp_d = 1'b1;
                    snoopa_d = ptr_q;
                    snoopd_d = in_data;
                    ptr_d    = ptr_q + 8'd1;
                    cnt_d    = cnt_q - 9'd1;
                    sum_d    = sum_nx;
                    state_d  = (cnt_q == 9'd1) ? CSUM : DATA;
                end
            end
            CSUM: begin
                if (xfer) begin
                    busy_d      = 1'b0;
                    cpu_reset_d = (sum_nx != 8'h00);
                    error_d     = (sum_nx != 8'h00);
                    state_d     = (sum_nx == 8'h00) ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // idle-gap watchdog inside a frame; any transfer restarts it
        if (!xfer && state_q inside {ADDR, COUNT, DATA, CSUM}) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                tmo_d       = '0;
                error_d     = 1'b1;
                busy_d      = 1'b0;
                cpu_reset_d = 1'b1;
                state_d     = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 8'h00;
            sum_q       <= 8'h00;
            cnt_q       <= 9'h000;
            tmo_q       <= '0;
            snoopa_q    <= 8'h00;
            snoopd_q    <= 8'h00;
            snoopp_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            snoopa_q    <= snoopa_d;
            snoopd_q    <= snoopd_d;
            snoopp_q    <= snoopp_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            in_ready_q  <= in_ready_d;
        end
    end
    assign in_ready  = in_ready_q;
    assign snoopa    = snoopa_q;
    assign snoopd    = snoopd_q;
    assign snoopp    = snoopp_q;
    assign snoopm    = SPACE;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign error     = error_q;
endmodule

// File: tb/tb_discus_loader.sv
// tb_discus_loader: directed and randomized frame loads checked against a frame-level model.
module tb_discus_loader;
    localparam int TMO = 20;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] snoopa;
    logic [7:0] snoopd;
    logic       snoopp;
    logic       snoopm;
    logic       cpu_reset;
    logic       busy;
    logic       error;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         strobe_due = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] m_e;
    logic [7:0] dat[256];
    logic [7:0] prog[12] = '{8'h84, 8'hD4, 8'hE9, 8'hF2, 8'h0B, 8'h30,
                             8'h83, 8'hD4, 8'hD1, 8'hD1, 8'hD1, 8'h60};

    discus_loader #(.SYNC(8'hA5), .TIMEOUT(TMO), .SPACE(1'b0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .snoopa(snoopa), .snoopd(snoopd), .snoopp(snoopp),
        .snoopm(snoopm), .cpu_reset(cpu_reset), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_snoopa", {8'h00, snoopa}, 16'h0000);
        chk("rst_snoopd", {8'h00, snoopd}, 16'h0000);
        chk("rst_snoopp", {15'b0, snoopp}, 16'd0);
        chk("rst_cpu_reset", {15'b0, cpu_reset}, 16'd1);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_error", {15'b0, error}, 16'd0);
        chk("rst_in_ready", {15'b0, in_ready}, 16'd0);
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        for (int k = 0; !in_ready && k < 50; k++) @(negedge clk);
        if (!in_ready) chk("in_ready_wait", {15'b0, in_ready}, 16'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // sends header plus nsend payload bytes from dat[]; closes the frame when nsend == n
    task automatic send_frame(input logic [7:0] a, input int n, input int nsend,
                              input bit bad, input int gmax);
        logic [7:0] s;
        logic [7:0] c;
        c = 8'(n);
        s = a + c;
        put(8'hA5, $urandom_range(gmax, 0));
        chk("busy_after_sync", {15'b0, busy}, 16'd1);
        chk("cpu_reset_after_sync", {15'b0, cpu_reset}, 16'd1);
        chk("error_after_sync", {15'b0, error}, 16'd0);
        put(a, $urandom_range(gmax, 0));
        put(c, $urandom_range(gmax, 0));
        for (int i = 0; i < nsend; i++) begin
            exp_q.push_back({8'(a + i), dat[i]});
            s = s + dat[i];
            put(dat[i], $urandom_range(gmax, 0));
            strobe_due = 1'b1;
        end
        if (nsend == n) put(8'h00 - s + {7'b0, bad}, $urandom_range(gmax, 0));
    endtask

    task automatic chk_end(input bit good);
        chk("end_busy", {15'b0, busy}, 16'd0);
        chk("end_cpu_reset", {15'b0, cpu_reset}, {15'b0, !good});
        chk("end_error", {15'b0, error}, {15'b0, !good});
        chk("end_writes_left", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    chk("snoopp", {15'b0, snoopp}, {15'b0, strobe_due});
                    if (snoopp) begin
                        if (exp_q.size() == 0) begin
                            chk("write_expected", 16'(exp_q.size()), 16'd1);
                        end else begin
                            m_e = exp_q.pop_front();
                            chk("snoopa", {8'h00, snoopa}, {8'h00, m_e[15:8]});
                            chk("snoopd", {8'h00, snoopd}, {8'h00, m_e[7:0]});
                        end
                    end
                end
                strobe_due = 1'b0;
            end
        join_none
        repeat (2) @(negedge clk);
        chk_reset_vals();
        chk("snoopm", {15'b0, snoopm}, 16'd0);
        reset = 1'b1;
        chk("in_ready_at_release", {15'b0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", {15'b0, in_ready}, 16'd1);
        put(8'h12, 0);
        put(8'h34, 0);
        chk("garbage_busy", {15'b0, busy}, 16'd0);
        chk("garbage_cpu_reset", {15'b0, cpu_reset}, 16'd1);
        for (int i = 0; i < 12; i++) dat[i] = prog[i];
        send_frame(8'h00, 12, 12, 1'b0, 0);
        chk_end(1'b1);
        put(8'h77, 0);
        chk("run_garbage_cpu_reset", {15'b0, cpu_reset}, 16'd0);
        send_frame(8'h00, 12, 12, 1'b1, 0);
        chk_end(1'b0);
        send_frame(8'h00, 12, 12, 1'b0, 0);
        chk_end(1'b1);
        dat[0] = 8'h11;
        dat[1] = 8'h22;
        dat[2] = 8'h33;
        send_frame(8'hFE, 3, 3, 1'b0, 0);
        chk_end(1'b1);
        for (int i = 0; i < 256; i++) dat[i] = 8'(i);
        send_frame(8'h00, 256, 256, 1'b0, 0);
        chk_end(1'b1);
        for (int i = 0; i < 256; i++) dat[i] = 8'($urandom);
        send_frame(8'h40, 10, 4, 1'b0, 0);
        repeat (TMO - 3) @(negedge clk);
        chk("stall_busy", {15'b0, busy}, 16'd1);
        repeat (6) @(negedge clk);
        chk("timeout_error", {15'b0, error}, 16'd1);
        chk("timeout_busy", {15'b0, busy}, 16'd0);
        chk("timeout_cpu_reset", {15'b0, cpu_reset}, 16'd1);
        send_frame(8'h20, 6, 6, 1'b0, 1);
        chk_end(1'b1);
        for (int f = 0; f < 25; f++) begin
            int n;
            bit bad;
            n   = $urandom_range(24, 1);
            bad = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < n; i++) dat[i] = 8'($urandom);
            send_frame(8'($urandom), n, n, bad, 2);
            chk_end(!bad);
        end
        for (int i = 0; i < 20; i++) dat[i] = 8'($urandom);
        send_frame(8'h80, 20, 5, 1'b0, 1);
        #2;
        reset = 1'b0;
        strobe_due = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("in_ready_at_rerelease", {15'b0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_reedge", {15'b0, in_ready}, 16'd1);
        send_frame(8'hF0, 20, 20, 1'b0, 0);
        chk_end(1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
